sd_apb_mchan_ctrl: RTL and testbench
====================================

SD_APB_MCHAN_CTRL -- requirements
Module: sd_apb_mchan_ctrl

Interface
REQ-001 Parameter DATA_W, default 16: APB data, buffer and register width.
REQ-002 Parameter NUM_CH, default 2: number of SD/SPI channels served, range 1..8.
REQ-003 Parameter WAIT_STATES, default 0: fixed wait cycles per transfer, range 0..3.
REQ-004 Parameter TIMEOUT_CYC, default 16: maximum flow-control stall cycles, range 1..255.
REQ-005 Parameter ADDR_W, default 6: APB address width; it SHALL be at least 3+clog2(NUM_CH).
REQ-006 pclk  in  1  single clock; all logic on rising edge.
REQ-007 preset  in  1  asynchronous reset, active-low.
REQ-008 psel, penable, pwrite  in  1 each  APB control.
REQ-009 paddr  in  ADDR_W  [2:0] register offset, [ADDR_W-1:3] channel index.
REQ-010 pwdata  in  DATA_W; prdata  out  DATA_W; pready  out  1; pslverr  out  1.
REQ-011 data_o  out  DATA_W  write data to the selected channel, equal to pwdata at all times.
REQ-012 st_full_i  in  NUM_CH; st_enq_o  out  NUM_CH  per-channel store-buffer full flag and enqueue strobe.
REQ-013 ld_empty_i  in  NUM_CH; ld_data_i  in  NUM_CH*DATA_W; ld_deq_o  out  NUM_CH  per-channel load-buffer status, head data and dequeue strobe.
REQ-014 status_i  in  NUM_CH*DATA_W; addr_ld_o, ctrl_ld_o  out  NUM_CH  per-channel status word and register load strobes.

Function
REQ-015 Register map per channel: offset 0 W ST enqueue, 1 R LD dequeue, 2 W ADDR load, 3 W CTRL load, 4 R STATUS; all other offset/direction pairs and channel index >= NUM_CH are invalid.
REQ-016 The FSM SHALL have states IDLE, WAIT, STALL and DONE.
REQ-017 IDLE -> WAIT on psel & !penable (setup phase); the wait counter clears on entry.
REQ-018 WAIT: with penable high the counter increments each cycle; when it equals WAIT_STATES, go to DONE, or to STALL if offset 0 write with st_full_i[ch]=1 or offset 1 read with ld_empty_i[ch]=1.
REQ-019 STALL: when the blocking flag clears, go to DONE; after TIMEOUT_CYC stall cycles, go to DONE flagged as timed-out.
REQ-020 DONE: pready=1 for exactly one cycle, then IDLE; back-to-back setup in the next cycle is accepted.
REQ-021 Zero-wait latency: with a ready buffer and WAIT_STATES=0, pready asserts in the first penable cycle; each wait state adds one cycle.
REQ-022 Every strobe (st_enq_o, ld_deq_o, addr_ld_o, ctrl_ld_o) SHALL be one pulse, on the selected channel bit only, in the DONE cycle only, and SHALL be suppressed for invalid or timed-out transfers.
REQ-023 prdata SHALL equal ld_data_i or status_i slice of the selected channel in the DONE cycle of a valid read; otherwise all-ones.
REQ-024 psel or penable low in WAIT or STALL SHALL abort to IDLE with no strobe and no pready.
REQ-025 Channel index and offset SHALL be captured at setup; later paddr changes during the transfer are ignored.

Reset
REQ-026 On preset low: state IDLE, counters 0, pready 0, pslverr 0, all strobes 0, prdata all-ones, effective immediately and asynchronously.
REQ-027 Reset asserted mid-transfer SHALL drop the transfer with no strobe; the first transfer after reset release behaves normally.

Configuration
REQ-028 Macro SD_APB_PSLVERR_EN defined: pslverr=1 with pready in DONE for invalid address or timed-out transfers, 0 otherwise.
REQ-029 Macro SD_APB_PSLVERR_EN undefined: pslverr tied 0; invalid or timed-out transfers complete silently (read data all-ones, writes discarded).

Verification
REQ-030 WAIT_STATES=2, write 0x00A5 to ch1 offset 3 -> pready in 3rd penable cycle, ctrl_ld_o=2'b10 for one cycle, data_o=0x00A5.
REQ-031 Read ch0 offset 1, ld_empty_i[0]=1 for 5 cycles then 0, ld_data=0x1234 -> pready 1 cycle after empty clears, prdata=0x1234, one ld_deq_o[0] pulse.
REQ-032 Write ch0 offset 0 with st_full_i[0] held 1, TIMEOUT_CYC=16 -> pready after 16 stall cycles, no st_enq_o, pslverr=1 only with SD_APB_PSLVERR_EN.
REQ-033 Read ch3 offset 4 with NUM_CH=2 -> prdata=0xFFFF, no strobes, pslverr per macro.
REQ-034 Drop penable in STALL, then preset low during a second transfer -> IDLE, no strobes, all outputs at reset values; next write completes normally.

Source files
------------

// File: rtl/sd_apb_mchan_ctrl.sv
// APB slave front-end for NUM_CH SD/SPI channels: store/load buffer access plus ADDR/CTRL/STATUS registers.
// Optional macro SD_APB_PSLVERR_EN reports invalid or timed-out transfers on pslverr.
module sd_apb_mchan_ctrl #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned ADDR_W      = 6
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [ADDR_W-1:0]        paddr,
  input  logic [DATA_W-1:0]        pwdata,
  output logic [DATA_W-1:0]        prdata,
  output logic                     pready,
  output logic                     pslverr,
  output logic [DATA_W-1:0]        data_o,
  input  logic [NUM_CH-1:0]        st_full_i,
  output logic [NUM_CH-1:0]        st_enq_o,
  input  logic [NUM_CH-1:0]        ld_empty_i,
  input  logic [NUM_CH*DATA_W-1:0] ld_data_i,
  output logic [NUM_CH-1:0]        ld_deq_o,
  input  logic [NUM_CH*DATA_W-1:0] status_i,
  output logic [NUM_CH-1:0]        addr_ld_o,
  output logic [NUM_CH-1:0]        ctrl_ld_o
);

  localparam int unsigned CH_W    = ADDR_W - 3;
  localparam logic [1:0]  WS_LAST = 2'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STALL, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d, cur_ch;
  logic [2:0]        off_q, off_d, cur_off;
  logic              wr_q, wr_d, cur_wr;
  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic [7:0]        stall_cnt_q, stall_cnt_d;
  logic              to_q, to_d;
  logic [NUM_CH-1:0] ch_oh;
  logic [DATA_W-1:0] ld_word, status_word;
  logic              off_ok, valid, blocked, done_ok;

  // In IDLE the live address is decoded so the setup cycle can already resolve the first step.
  always_comb begin
    cur_ch      = (state_q == S_IDLE) ? paddr[ADDR_W-1:3] : ch_q;
    cur_off     = (state_q == S_IDLE) ? paddr[2:0]        : off_q;
    cur_wr      = (state_q == S_IDLE) ? pwrite            : wr_q;
    ch_oh       = '0;
    ld_word     = '0;
    status_word = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cur_ch == CH_W'(i)) begin
        ch_oh[i]    = 1'b1;
        ld_word     = ld_data_i[i*DATA_W +: DATA_W];
        status_word = status_i[i*DATA_W +: DATA_W];
      end
    end
    case (cur_off)
      3'd0, 3'd2, 3'd3: off_ok = cur_wr;
      3'd1, 3'd4:       off_ok = !cur_wr;
      default:          off_ok = 1'b0;
    endcase
    valid   = (|ch_oh) && off_ok;
    blocked = valid && (((cur_off == 3'd0) && cur_wr && |(st_full_i & ch_oh)) ||
                        ((cur_off == 3'd1) && !cur_wr && |(ld_empty_i & ch_oh)));
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    off_d       = off_q;
    wr_d        = wr_q;
    wait_cnt_d  = wait_cnt_q;
    stall_cnt_d = stall_cnt_q;
    to_d        = to_q;
    case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          ch_d        = paddr[ADDR_W-1:3];
          off_d       = paddr[2:0];
          wr_d        = pwrite;
          wait_cnt_d  = '0;
          stall_cnt_d = '0;
          to_d        = 1'b0;
          // With no wait states the WAIT step collapses into setup so DONE lands on the first penable cycle.
          if (WAIT_STATES == 0) state_d = blocked ? S_STALL : S_DONE;
          else                  state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!psel || !penable) begin
          state_d = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
          if (wait_cnt_q == WS_LAST) state_d = blocked ? S_STALL : S_DONE;
        end
      end
      S_STALL: begin
        if (!psel || !penable) begin
          state_d = S_IDLE;
        end else if (!blocked) begin
          state_d = S_DONE;
        end else if (stall_cnt_q == TO_LAST) begin
          state_d = S_DONE;
          to_d    = 1'b1;
        end else begin
          stall_cnt_d = stall_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      off_q       <= '0;
      wr_q        <= 1'b0;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      off_q       <= off_d;
      wr_q        <= wr_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      to_q        <= to_d;
    end
  end

  always_comb begin
    pready    = (state_q == S_DONE);
    done_ok   = pready && valid && !to_q;
    st_enq_o  = (done_ok && cur_off == 3'd0) ? ch_oh : '0;
    ld_deq_o  = (done_ok && cur_off == 3'd1) ? ch_oh : '0;
    addr_ld_o = (done_ok && cur_off == 3'd2) ? ch_oh : '0;
    ctrl_ld_o = (done_ok && cur_off == 3'd3) ? ch_oh : '0;
    prdata    = '1;
    if (done_ok && !cur_wr) prdata = (cur_off == 3'd1) ? ld_word : status_word;
    data_o    = pwdata;
`ifdef SD_APB_PSLVERR_EN
    pslverr   = pready && (!valid || to_q);
`else
    pslverr   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_sd_apb_mchan_ctrl.sv
// Scoreboard bench for sd_apb_mchan_ctrl: a zero-wait instance and a two-wait-state instance share one APB bus.
module tb_sd_apb_mchan_ctrl;

`ifdef SD_APB_PSLVERR_EN
  localparam logic PSLV = 1'b1;
`else
  localparam logic PSLV = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] rd;
    logic        err;
    logic [1:0]  st;
    logic [1:0]  ld;
    logic [1:0]  ad;
    logic [1:0]  ct;
    logic [15:0] dat;
  } exp_t;

  logic        pclk = 1'b0;
  logic        preset = 1'b0;
  logic        psel0 = 1'b0, psel2 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [5:0]  paddr = '0;
  logic [15:0] pwdata = '0;
  logic [1:0]  st_full = '0, ld_empty = '0;
  logic [31:0] ld_data = {16'h5678, 16'h1234};
  logic [31:0] status  = {16'hBEEF, 16'hCAFE};

  logic [15:0] prdata0, data0, prdata2, data2;
  logic        pready0, pslverr0, pready2, pslverr2;
  logic [1:0]  st_enq0, ld_deq0, addr_ld0, ctrl_ld0;
  logic [1:0]  st_enq2, ld_deq2, addr_ld2, ctrl_ld2;

  exp_t q0[$];
  exp_t q2[$];
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 pclk = ~pclk;

  sd_apb_mchan_ctrl #(.DATA_W(16), .NUM_CH(2), .WAIT_STATES(0), .TIMEOUT_CYC(16), .ADDR_W(6)) u_dut0 (
    .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
    .data_o(data0), .st_full_i(st_full), .st_enq_o(st_enq0), .ld_empty_i(ld_empty),
    .ld_data_i(ld_data), .ld_deq_o(ld_deq0), .status_i(status),
    .addr_ld_o(addr_ld0), .ctrl_ld_o(ctrl_ld0));

  sd_apb_mchan_ctrl #(.DATA_W(16), .NUM_CH(2), .WAIT_STATES(2), .TIMEOUT_CYC(16), .ADDR_W(6)) u_dut2 (
    .pclk(pclk), .preset(preset), .psel(psel2), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata2), .pready(pready2), .pslverr(pslverr2),
    .data_o(data2), .st_full_i(st_full), .st_enq_o(st_enq2), .ld_empty_i(ld_empty),
    .ld_data_i(ld_data), .ld_deq_o(ld_deq2), .status_i(status),
    .addr_ld_o(addr_ld2), .ctrl_ld_o(ctrl_ld2));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic [15:0] rd, input logic err, input logic [1:0] st,
                              input logic [1:0] ld, input logic [1:0] ad, input logic [1:0] ct,
                              input logic [15:0] dat);
    exp_t e;
    e = {rd, err, st, ld, ad, ct, dat};
    return e;
  endfunction

  task automatic mon(input int id, input logic rdy, input logic err, input logic [15:0] rd,
                     input logic [15:0] dat, input logic [1:0] st, input logic [1:0] ld,
                     input logic [1:0] ad, input logic [1:0] ct);
    exp_t a, e;
    a = {rd, err, st, ld, ad, ct, dat};
    if (rdy) begin
      if ((id == 0 && q0.size() == 0) || (id != 0 && q2.size() == 0)) begin
        check($sformatf("unexpected_pready_dut%0d", id), 64'(rdy), 64'd0);
      end else begin
        if (id == 0) e = q0.pop_front();
        else         e = q2.pop_front();
        check($sformatf("xfer_dut%0d", id), 64'(a), 64'(e));
      end
    end else begin
      check($sformatf("idle_outputs_dut%0d", id), 64'({err, st, ld, ad, ct, rd}), 64'({9'b0, 16'hFFFF}));
    end
  endtask

  always @(negedge pclk) begin
    if (preset) begin
      mon(0, pready0, pslverr0, prdata0, data0, st_enq0, ld_deq0, addr_ld0, ctrl_ld0);
      mon(2, pready2, pslverr2, prdata2, data2, st_enq2, ld_deq2, addr_ld2, ctrl_ld2);
    end
  end

  task automatic check_reset_outputs(input string name);
    check({name, "_dut0"}, 64'({pready0, pslverr0, st_enq0, ld_deq0, addr_ld0, ctrl_ld0, prdata0}),
          64'({10'b0, 16'hFFFF}));
    check({name, "_dut2"}, 64'({pready2, pslverr2, st_enq2, ld_deq2, addr_ld2, ctrl_ld2, prdata2}),
          64'({10'b0, 16'hFFFF}));
  endtask

  // One APB transfer; paddr is scrambled after setup to confirm the DUT uses its captured copy.
  task automatic xfer(input int dut, input logic wr, input logic [5:0] addr, input logic [15:0] wd,
                      input exp_t e, input int lat);
    int  n;
    logic got;
    if (dut == 0) q0.push_back(e);
    else          q2.push_back(e);
    @(posedge pclk); #1;
    psel0 = (dut == 0); psel2 = (dut != 0);
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge pclk); #1;
    penable = 1'b1; paddr = addr ^ 6'h3F;
    n = 1; got = 1'b0;
    while (!got && n <= 40) begin
      @(negedge pclk);
      if ((dut == 0) ? pready0 : pready2) got = 1'b1;
      else begin
        @(posedge pclk); #1;
        n++;
      end
    end
    check($sformatf("latency_dut%0d_addr%h", dut, addr), got ? 64'(n) : 64'hFFFF_FFFF, 64'(lat));
  endtask

  task automatic idle(input int n);
    @(posedge pclk); #1;
    psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
    repeat (n - 1) @(posedge pclk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_reset_outputs("reset_state");
    repeat (3) @(posedge pclk);
    #1 preset = 1'b1;

    xfer(0, 1'b1, 6'h00, 16'h1111, mk(16'hFFFF, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 16'h1111), 1);
    xfer(0, 1'b1, 6'h0A, 16'h2222, mk(16'hFFFF, 1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 16'h2222), 1);
    xfer(0, 1'b0, 6'h0C, 16'h0000, mk(16'hBEEF, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000), 1);
    xfer(0, 1'b0, 6'h09, 16'h0000, mk(16'h5678, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 16'h0000), 1);
    xfer(0, 1'b1, 6'h01, 16'h3333, mk(16'hFFFF, PSLV, 2'b00, 2'b00, 2'b00, 2'b00, 16'h3333), 1);
    xfer(0, 1'b0, 6'h05, 16'h0000, mk(16'hFFFF, PSLV, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000), 1);
    xfer(0, 1'b0, 6'h1C, 16'h0000, mk(16'hFFFF, PSLV, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000), 1);
    xfer(2, 1'b1, 6'h0B, 16'h00A5, mk(16'hFFFF, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 16'h00A5), 3);
    xfer(2, 1'b0, 6'h04, 16'h0000, mk(16'hCAFE, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000), 3);
    idle(2);

    ld_empty = 2'b01;
    fork
      xfer(0, 1'b0, 6'h01, 16'h0000, mk(16'h1234, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 16'h0000), 6);
      begin
        repeat (6) @(posedge pclk);
        #1 ld_empty = 2'b00;
      end
    join
    idle(2);

    st_full = 2'b01;
    xfer(0, 1'b1, 6'h00, 16'h4444, mk(16'hFFFF, PSLV, 2'b00, 2'b00, 2'b00, 2'b00, 16'h4444), 17);
    idle(2);

    // Abort in STALL: penable/psel dropped, DUT must never raise pready for this transfer.
    @(posedge pclk); #1;
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 6'h00; pwdata = 16'h5555;
    @(posedge pclk); #1 penable = 1'b1;
    repeat (3) @(posedge pclk);
    #1 psel0 = 1'b0; penable = 1'b0;
    repeat (20) @(posedge pclk);

    // Reset arrives in the DONE cycle of a transfer on ch1.
    st_full = 2'b10;
    #1 psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 6'h08; pwdata = 16'h6666;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 st_full = 2'b00;
    @(posedge pclk); #1 preset = 1'b0;
    #1 check_reset_outputs("reset_mid_transfer");
    psel0 = 1'b0; penable = 1'b0;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b1;

    xfer(0, 1'b1, 6'h03, 16'h0F0F, mk(16'hFFFF, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 16'h0F0F), 1);
    idle(3);
    check("queue_dut0_drained", 64'(q0.size()), 64'd0);
    check("queue_dut2_drained", 64'(q2.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
